// File: rtl/cdc_arb_pkg.sv
// Shared types and defaults for the write-side round-robin arbiter.
// The optional burst lock is built only when CDC_WR_ARB_LOCK_EN is defined.
package cdc_arb_pkg;

    localparam int NREQ_DEF = 4;

    typedef logic [7:0] dat_def_t;
    typedef logic [$clog2(NREQ_DEF)-1:0] idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// Rotate-priority select: first valid bit at or above ptr, wrapping to 0.
module cdc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vld,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] rot;
    logic [IW:0]  sum;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        // Bit k of rot is requester (ptr + k) mod N.
        rot    = N'({vld, vld} >> ptr);
        for (int k = 0; k < N; k++) begin
            if (!any && rot[k]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                idx = IW'(sum);
            end
        end
        if (any) begin
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/cdc_wr_arb.sv
// Round-robin arbiter feeding one FIFO write port through a single output register.
// Define CDC_WR_ARB_LOCK_EN to hold the grant on one requester until req_last.
module cdc_wr_arb
    import cdc_arb_pkg::*;
#(
    parameter int  NREQ  = NREQ_DEF,
    parameter type dat_t = dat_def_t
) (
    input  logic                    wclk,
    input  logic                    wrst_n,
    input  logic [NREQ-1:0]         req_vld,
    input  dat_t                    req_data [NREQ],
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_rdy,
    output dat_t                    wdata,
    output logic                    wput,
    input  logic                    wrdy,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output state_e                  dbg_state,
    output logic [$clog2(NREQ)-1:0] dbg_rr_ptr
);

    localparam int IW = $clog2(NREQ);

    // Handshake: a beat moves on a posedge where valid && ready on that side;
    // req_rdy is combinational, wput/wdata are registered and hold while !wrdy.
    logic            wput_q, wput_d;
    dat_t            wdata_q, wdata_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    state_e          state_q, state_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            can_take;
    logic            accept;
    logic [IW-1:0]   nxt_idx;

`ifdef CDC_WR_ARB_LOCK_EN
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
`else
    logic            unused_last;
    assign unused_last = ^req_last;
`endif

    always_comb begin
        elig = req_vld;
`ifdef CDC_WR_ARB_LOCK_EN
        if (state_q == LOCKED) begin
            elig = req_vld & (NREQ'(1) << lock_idx_q);
        end
`endif
    end

    cdc_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .vld    (elig),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign can_take = !wput_q || wrdy;
    assign accept   = wrst_n && pick_any && can_take;
    assign req_rdy  = accept ? pick_onehot : '0;
    assign nxt_idx  = IW'(wrap_inc(int'(pick_idx), NREQ));

    always_comb begin
        wput_d   = wput_q && !wrdy;
        wdata_d  = wdata_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        state_d  = state_q;
`ifdef CDC_WR_ARB_LOCK_EN
        lock_idx_d = lock_idx_q;
`endif
        if (accept) begin
            wput_d  = 1'b1;
            wdata_d = req_data[pick_idx];
            gnt_d   = pick_idx;
`ifdef CDC_WR_ARB_LOCK_EN
            if (req_last[pick_idx]) begin
                state_d  = IDLE;
                rr_ptr_d = nxt_idx;
            end else begin
                state_d    = LOCKED;
                lock_idx_d = pick_idx;
            end
`else
            rr_ptr_d = nxt_idx;
`endif
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wput_q   <= 1'b0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            state_q  <= IDLE;
`ifdef CDC_WR_ARB_LOCK_EN
            lock_idx_q <= '0;
`endif
        end else begin
            wput_q   <= wput_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= state_d;
`ifdef CDC_WR_ARB_LOCK_EN
            lock_idx_q <= lock_idx_d;
`endif
        end
    end

    assign wput       = wput_q;
    assign wdata      = wdata_q;
    assign gnt_idx    = gnt_q;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_cdc_wr_arb.sv
// Bench for cdc_wr_arb: directed scenarios plus a randomized run against a behavioural model.
// Lock-dependent expectations follow CDC_WR_ARB_LOCK_EN.
module tb_cdc_wr_arb;
    import cdc_arb_pkg::*;

    localparam int N = 4;
    typedef logic [7:0] d_t;

    logic         wclk = 1'b0;
    logic         wrst_n;
    logic [N-1:0] req_vld;
    d_t           req_data [N];
    logic [N-1:0] req_last;
    logic [N-1:0] req_rdy;
    d_t           wdata;
    logic         wput;
    logic         wrdy;
    logic [1:0]   gnt_idx;
    state_e       dbg_state;
    logic [1:0]   dbg_rr_ptr;

    cdc_wr_arb #(
        .NREQ  (N),
        .dat_t (logic [7:0])
    ) dut (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .req_vld    (req_vld),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_rdy    (req_rdy),
        .wdata      (wdata),
        .wput       (wput),
        .wrdy       (wrdy),
        .gnt_idx    (gnt_idx),
        .dbg_state  (dbg_state),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    always #5 wclk = ~wclk;

    // Reference model state: output register contents, pointer, lock owner.
    bit   m_wput;
    d_t   m_wdata;
    int   m_gnt;
    int   m_ptr;
    bit   m_locked;
    int   m_lock;
    int   last_pick;

    logic [9:0] exp_q[$];
    int   acc_cnt [N];
    int   wr_cnt [N];
    int   wr_total;
    int   checks;
    int   errors;

    task automatic model_reset();
        m_wput    = 1'b0;
        m_wdata   = '0;
        m_gnt     = 0;
        m_ptr     = 0;
        m_locked  = 1'b0;
        m_lock    = 0;
        last_pick = -1;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            acc_cnt[i] = 0;
            wr_cnt[i]  = 0;
        end
    endtask

    // One clock: compare at negedge, update model and scoreboard, step past posedge.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic [9:0]   e;
        int           pick;
        bit           can;
        @(negedge wclk);
        can  = !m_wput || wrdy;
        pick = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (pick < 0 && req_vld[j] && (!m_locked || j == m_lock)) pick = j;
        end
        exp_rdy = '0;
        if (can && pick >= 0) exp_rdy[pick] = 1'b1;

        checks++;
        if (req_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL req_rdy got %b exp %b t=%0t", req_rdy, exp_rdy, $time);
        end
        checks++;
        if (wput !== m_wput) begin
            errors++;
            $display("FAIL wput got %b exp %b t=%0t", wput, m_wput, $time);
        end
        if (m_wput) begin
            checks++;
            if (wdata !== m_wdata || gnt_idx !== 2'(m_gnt)) begin
                errors++;
                $display("FAIL out_reg got %0d/%h exp %0d/%h t=%0t",
                         gnt_idx, wdata, m_gnt, m_wdata, $time);
            end
        end
        checks++;
        if (dbg_rr_ptr !== 2'(m_ptr)) begin
            errors++;
            $display("FAIL rr_ptr got %0d exp %0d t=%0t", dbg_rr_ptr, m_ptr, $time);
        end

        if (wput === 1'b1 && wrdy) begin
            checks++;
            wr_total++;
            wr_cnt[gnt_idx]++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write got %0d/%h exp none t=%0t", gnt_idx, wdata, $time);
            end else begin
                e = exp_q.pop_front();
                if ({gnt_idx, wdata} !== e) begin
                    errors++;
                    $display("FAIL sb_write got %0d/%h exp %0d/%h t=%0t",
                             gnt_idx, wdata, e[9:8], e[7:0], $time);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_vld[i] && req_rdy[i]) begin
                exp_q.push_back({2'(i), req_data[i]});
                acc_cnt[i]++;
            end
        end

        last_pick = (can && pick >= 0) ? pick : -1;
        if (m_wput && wrdy) m_wput = 1'b0;
        if (last_pick >= 0) begin
            m_wput  = 1'b1;
            m_wdata = req_data[pick];
            m_gnt   = pick;
`ifdef CDC_WR_ARB_LOCK_EN
            if (req_last[pick]) begin
                m_locked = 1'b0;
                m_ptr    = (pick + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_lock   = pick;
            end
`else
            m_ptr = (pick + 1) % N;
`endif
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic drain();
        req_vld = '0;
        wrdy    = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        wrst_n   = 1'b0;
        req_vld  = '1;
        req_last = '1;
        wrdy     = 1'b1;
        for (int i = 0; i < N; i++) req_data[i] = 8'(8'h30 + i);
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        checks++;
        if (wput !== 1'b0 || wdata !== 8'h00 || gnt_idx !== 2'd0 || dbg_rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL reset_vals got %b/%h/%0d/%0d exp 0/00/0/0",
                     wput, wdata, gnt_idx, dbg_rr_ptr);
        end
        checks++;
        if (req_rdy !== 4'b0000 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_rdy got %b/%0d exp 0000/IDLE", req_rdy, dbg_state);
        end
        wrst_n = 1'b1;
        cycle();
        wrdy = 1'b0;
        cycle();
        #2;
        wrst_n = 1'b0;
        #1;
        checks++;
        if (wput !== 1'b0 || req_rdy !== 4'b0000 || wdata !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%h exp 0/0000/00", wput, req_rdy, wdata);
        end
        model_reset();
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0001 || dbg_rr_ptr !== 2'd0) begin
            errors++;
            $display("FAIL tie_after_reset got %b/%0d exp 0001/0", req_rdy, dbg_rr_ptr);
        end
    endtask

    task automatic test_fairness();
        req_vld  = '1;
        req_last = '1;
        wrdy     = 1'b1;
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < N; i++) req_data[i] = 8'(16 * i + b);
            cycle();
            checks++;
            if (wput !== 1'b1 || gnt_idx !== 2'(b % 4)) begin
                errors++;
                $display("FAIL fair_seq beat %0d got %b/%0d exp 1/%0d", b, wput, gnt_idx, b % 4);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int w0;
        req_vld     = 4'b0001;
        req_last    = '1;
        req_data[0] = 8'hA5;
        wrdy        = 1'b1;
        cycle();
        req_vld = '1;
        for (int i = 0; i < N; i++) req_data[i] = 8'h5A;
        wrdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (wput !== 1'b1 || wdata !== 8'hA5 || req_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got %b/%h/%b exp 1/a5/0000", c, wput, wdata, req_rdy);
            end
        end
        req_vld = '0;
        wrdy    = 1'b1;
        w0      = wr_total;
        cycle();
        cycle();
        checks++;
        if (wr_total - w0 !== 1 || wput !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got %0d writes wput %b exp 1 writes wput 0", wr_total - w0, wput);
        end
    endtask

    task automatic test_sparse();
        req_vld     = 4'b0100;
        req_last    = '1;
        wrdy        = 1'b1;
        req_data[2] = 8'h11;
        cycle();
        checks++;
        if (gnt_idx !== 2'd2 || wdata !== 8'h11) begin
            errors++;
            $display("FAIL sparse_b0 got %0d/%h exp 2/11", gnt_idx, wdata);
        end
        req_data[2] = 8'h22;
        cycle();
        checks++;
        if (gnt_idx !== 2'd2 || wdata !== 8'h22) begin
            errors++;
            $display("FAIL sparse_b1 got %0d/%h exp 2/22", gnt_idx, wdata);
        end
        req_vld = '0;
        cycle();
        checks++;
        if (dbg_rr_ptr !== 2'd3 || wput !== 1'b0) begin
            errors++;
            $display("FAIL sparse_ptr got %0d/%b exp 3/0", dbg_rr_ptr, wput);
        end
    endtask

    task automatic test_lock();
        int     exp_seq [5];
        state_e exp_st;
        int     r1;
`ifdef CDC_WR_ARB_LOCK_EN
        exp_seq = '{1, 1, 1, 3, 0};
        exp_st  = LOCKED;
`else
        exp_seq = '{1, 3, 0, 1, 3};
        exp_st  = IDLE;
`endif
        req_vld     = 4'b0001;
        req_last    = '1;
        wrdy        = 1'b1;
        req_data[0] = 8'hC0;
        cycle();
        r1 = 0;
        for (int b = 0; b < 5; b++) begin
            req_vld     = {1'b1, 1'b0, (r1 < 3), 1'b1};
            req_last[1] = (r1 == 2);
            for (int i = 0; i < N; i++) req_data[i] = 8'($urandom_range(0, 255));
            cycle();
            checks++;
            if (last_pick !== exp_seq[b] || gnt_idx !== 2'(exp_seq[b])) begin
                errors++;
                $display("FAIL lock_seq beat %0d got %0d exp %0d", b, gnt_idx, exp_seq[b]);
            end
            if (b == 0) begin
                checks++;
                if (dbg_state !== exp_st) begin
                    errors++;
                    $display("FAIL lock_state got %0d exp %0d", dbg_state, exp_st);
                end
            end
            if (last_pick == 1) r1++;
        end
        req_last = '1;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            req_vld  = N'($urandom);
            req_last = N'($urandom);
            wrdy     = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) req_data[i] = 8'($urandom);
            cycle();
        end
        req_last = '1;
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d beats exp 0", exp_q.size());
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (acc_cnt[i] != wr_cnt[i]) begin
                errors++;
                $display("FAIL sb_count req %0d got %0d writes exp %0d", i, wr_cnt[i], acc_cnt[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wr_total = 0;
        test_reset();
        test_fairness();
        test_backpressure();
        test_sparse();
        test_lock();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_wr_arb.md
CDC_WR_ARB -- requirements
Module: cdc_wr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter dat_t, default logic [7:0], payload type.
REQ-003 SHALL have port wclk  input  1  sole clock; all state rises on posedge wclk.
REQ-004 SHALL have port wrst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_vld  input  NREQ  per-requester data-valid.
REQ-006 SHALL have port req_data  input  NREQ x dat_t  per-requester payload.
REQ-007 SHALL have port req_last  input  NREQ  last beat of a burst; used only under the lock feature.
REQ-008 SHALL have port req_rdy  output  NREQ  per-requester accept strobe.
REQ-009 SHALL have port wdata  output  dat_t  payload to the FIFO write port.
REQ-010 SHALL have port wput  output  1  write request to the FIFO.
REQ-011 SHALL have port wrdy  input  1  FIFO not-full indication.
REQ-012 SHALL have port gnt_idx  output  $clog2(NREQ)  index of the requester owning the current wdata.

Function
REQ-013 Requester beat accepted on a posedge where req_vld[i] && req_rdy[i]; FIFO write occurs on a posedge where wput && wrdy.
REQ-014 Output register: wput/wdata/gnt_idx are registered; an accepted beat appears on wput one cycle later (latency 1).
REQ-015 req_rdy SHALL be one-hot or zero, combinational: req_rdy[i] = (pick == i) && req_vld[i] && (!wput || wrdy).
REQ-016 wput/wdata SHALL hold stable while wput && !wrdy; no beat lost or duplicated.
REQ-017 wput deasserts after a FIFO write if no new beat is accepted in the same cycle; back-to-back writes at 1/cycle when wrdy stays high.
REQ-018 Round-robin: pick = first requester with req_vld set, searching from rr_ptr upward with wrap NREQ-1 -> 0.
REQ-019 rr_ptr SHALL advance to (accepted index + 1) mod NREQ on each acceptance (unlocked case); unchanged otherwise.
REQ-020 No requester valid -> req_rdy all zero, rr_ptr unchanged.
REQ-021 req_vld deasserted by a non-granted requester SHALL NOT affect the current output register.

Reset
REQ-022 wrst_n low SHALL asynchronously force wput=0, wdata=0, gnt_idx=0, rr_ptr=0, state=IDLE; req_rdy=0 while in reset.
REQ-023 Reset mid-transfer SHALL discard the held beat; first post-reset acceptance no earlier than the first posedge with wrst_n high.

Configuration
REQ-024 Macro CDC_WR_ARB_LOCK_EN defined: FSM IDLE/LOCKED; acceptance without req_last -> LOCKED on that index, only that requester eligible, rr_ptr frozen; acceptance with req_last -> IDLE, rr_ptr = index+1; single beat with req_last stays IDLE.
REQ-025 Macro not defined: no FSM, req_last ignored, arbitration every beat per REQ-019.

Structure
REQ-026 Package cdc_arb_pkg SHALL hold dat_t default, NREQ default, idx_t and the LOCKED/IDLE state enum.
REQ-027 Sub-module cdc_rr_pick (combinational rotate-priority select: vld vector, ptr -> one-hot, index, any) SHALL be instantiated once.

Verification
REQ-028 Reset: wrst_n=0 mid-burst with wput=1 -> wput=0, req_rdy=0 immediately; after release rr_ptr=0, req 0 wins a 4-way tie.
REQ-029 Fairness: all 4 req_vld held, wrdy=1, 8 beats -> gnt_idx sequence 0,1,2,3,0,1,2,3; one FIFO write per cycle.
REQ-030 Backpressure: wrdy=0 for 5 cycles with wput=1, wdata=0xA5 -> wdata holds 0xA5, req_rdy all 0; wrdy=1 -> exactly one write of 0xA5.
REQ-031 Sparse: only req 2 valid with data 0x11,0x22 -> both written in order, gnt_idx=2, rr_ptr=3 afterwards.
REQ-032 LOCK_EN: req 1 burst 3 beats (last on 3rd) while req 0,3 valid -> gnt_idx 1,1,1 then 3 (rr_ptr=2 skips idle 2), then 0.
REQ-033 Scoreboard: random req_vld/wrdy for 10000 cycles -> every accepted beat written once, per-requester order preserved.
